// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with a small instruction buffer.
//
// Issues one word-aligned fetch at a time to instruction memory, queues the
// returned words together with their PCs in a FIFO, and presents the FIFO
// head to the decoder. A redirect from execute flushes the buffer, retargets
// the fetch PC, and makes sure any response still in flight is thrown away.
//
// Ports:
//   clk            - single clock, rising-edge
//   rst_n          - synchronous active-low reset
//   imem_req       - fetch request valid
//   imem_addr      - fetch address (always the current fetch PC)
//   imem_gnt       - memory accepted the request this cycle
//   imem_rvalid    - response data valid
//   imem_rdata     - fetched instruction word
//   redirect_valid - branch/jump redirect from execute
//   redirect_pc    - redirect target (low two bits are cleared)
//   inst_valid     - buffer head valid toward the decoder
//   inst           - buffer head instruction
//   inst_pc        - PC of the buffer head
//   inst_ready     - decoder consumes the head this cycle
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PTR_W = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

    // WAIT: a live request is outstanding; DROP: the outstanding response
    // belongs to a flushed path and must be discarded when it arrives.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        fetch_pc;
    logic [31:0]        req_pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        pc_mem   [IBUF_DEPTH];
    logic [31:0]        inst_mem [IBUF_DEPTH];

    logic grant;
    logic push;
    logic pop;

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = inst_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    // Redirect outranks every other update: no push, no pop, no grant.
    assign grant = imem_req & imem_gnt;
    assign push  = (state == S_WAIT) & imem_rvalid & ~redirect_valid;
    assign pop   = inst_valid & inst_ready & ~redirect_valid;

    always_comb begin
        state_next = state;
        imem_req   = rst_n && (state == S_IDLE) &&
                     (count < CNT_W'(IBUF_DEPTH)) && !redirect_valid;
        case (state)
            S_IDLE: begin
                if (grant) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) state_next = imem_rvalid ? S_IDLE : S_DROP;
                else if (imem_rvalid) state_next = S_IDLE;
            end
            S_DROP: begin
                // The awaited response retires the stale request even when a
                // further redirect lands in the same cycle; otherwise the FSM
                // would wait forever for a response that has already come.
                if (imem_rvalid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            state <= state_next;

            if (redirect_valid) begin
                // Masking (rather than slicing) keeps every redirect_pc bit in use.
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (grant) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]   <= req_pc;
                    inst_mem[wr_ptr] <= imem_rdata;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h1C00_0000;
    localparam int          D   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch PC, queue of {pc, inst}, and whether a request
    // is outstanding (0 none, 1 live, 2 stale after a redirect).
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic [63:0] m_q[$];
    int          m_out;
    bit          m_granted;

    inst_fetch #(.RESET_PC(RPC), .IBUF_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic bit exp_req();
        return (rst_n === 1'b1) && (m_out == 0) && (m_q.size() < D) && (redirect_valid !== 1'b1);
    endfunction

    task automatic model_update();
        bit req;
        bit do_push;
        m_granted = 1'b0;
        if (!rst_n) begin
            m_pc = RPC;
            m_q.delete();
            m_out = 0;
        end else begin
            req = exp_req();
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc & ~32'd3;
                if (m_out != 0) m_out = imem_rvalid ? 0 : 2;
            end else begin
                do_push = (m_out == 1) && imem_rvalid;
                if (m_out != 0 && imem_rvalid) m_out = 0;
                if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
                if (do_push) m_q.push_back({m_req_pc, imem_rdata});
                if (req && imem_gnt) begin
                    m_req_pc  = m_pc;
                    m_pc      = m_pc + 32'd4;
                    m_out     = 1;
                    m_granted = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_low: got %b want 0", imem_req); end
        cycle(); cycle();
        imem_gnt = 1'b0;
        rst_n = 1'b1;
        #2;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req_after: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    endtask

    task automatic test_single();
        do_reset();
        imem_gnt = 1'b1; inst_ready = 1'b1;
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0280_0400;
        cycle();
        imem_rvalid = 1'b0; inst_ready = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", inst_valid); end
        n_checks++; if (inst !== 32'h0280_0400) begin n_fail++; $display("FAIL single_inst: got %h want 02800400", inst); end
        n_checks++; if (inst_pc !== 32'h1C00_0000) begin n_fail++; $display("FAIL single_pc: got %h want 1c000000", inst_pc); end
        n_checks++; if (imem_addr !== 32'h1C00_0004) begin n_fail++; $display("FAIL single_next_addr: got %h want 1c000004", imem_addr); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
    endtask

    task automatic test_full();
        bit g_prev;
        bit g_now;
        do_reset();
        g_prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_gnt = 1'b1; imem_rvalid = g_prev; imem_rdata = 32'hA000_0000 + i;
            #2;
            if (i >= 4) begin
                n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req_%0d: got %b want 0", i, imem_req); end
            end
            g_now = imem_req & imem_gnt;
            g_prev = g_now;
            cycle();
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", inst_valid); end
        n_checks++; if (inst_pc !== 32'h1C00_0000) begin n_fail++; $display("FAIL full_head_pc: got %h want 1c000000", inst_pc); end
        n_checks++; if (inst !== 32'hA000_0001) begin n_fail++; $display("FAIL full_head_inst: got %h want a0000001", inst); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        #2;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL full_reenable: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h1C00_0008) begin n_fail++; $display("FAIL full_addr: got %h want 1c000008", imem_addr); end
        n_checks++; if (inst_pc !== 32'h1C00_0004) begin n_fail++; $display("FAIL full_second_pc: got %h want 1c000004", inst_pc); end
        n_checks++; if (inst !== 32'hA000_0003) begin n_fail++; $display("FAIL full_second_inst: got %h want a0000003", inst); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", inst_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1C00_0103;
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_during: got %b want 0", imem_req); end
        cycle();
        redirect_valid = 1'b0;
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_drop: got %b want 0", imem_req); end
        cycle();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        imem_rvalid = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dropped: got %b want 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req_idle: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h1C00_0100) begin n_fail++; $display("FAIL redir_addr: got %h want 1c000100", imem_addr); end
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
        cycle();
        imem_rvalid = 1'b0;
        #2;
        n_checks++; if (inst_pc !== 32'h1C00_0100) begin n_fail++; $display("FAIL redir_inst_pc: got %h want 1c000100", inst_pc); end
        n_checks++; if (inst !== 32'h1111_2222) begin n_fail++; $display("FAIL redir_inst: got %h want 11112222", inst); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0000;
        cycle();
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #2;
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL coin_pre_valid: got %b want 1", inst_valid); end
        cycle();
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0000; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h1C00_0200;
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL coin_valid: got %b want 0", inst_valid); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL coin_idle_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h1C00_0200) begin n_fail++; $display("FAIL coin_addr: got %h want 1c000200", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0; imem_gnt = 1'b1;
        #2;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); end
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0000;
        cycle();
        imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #2;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", imem_addr); end
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC000_0001;
        cycle();
        imem_rvalid = 1'b0;
        #2;
        n_checks++; if (inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc0: got %h want fffffffc", inst_pc); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL wrap_addr2: got %h want 00000004", imem_addr); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        #2;
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc1: got %h want 00000000", inst_pc); end
        n_checks++; if (inst !== 32'hC000_0001) begin n_fail++; $display("FAIL wrap_inst1: got %h want c0000001", inst); end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0; rst_n = 1'b0;
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_low: got %b want 0", imem_req); end
        cycle();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #2;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL rmid_addr: got %h want %h", imem_addr, RPC); end
        cycle();
        imem_rvalid = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ignored: got %b want 0", inst_valid); end
        imem_gnt = 1'b1;
        cycle();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h600D_600D;
        cycle();
        imem_rvalid = 1'b0;
        #2;
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_new_valid: got %b want 1", inst_valid); end
        n_checks++; if (inst !== 32'h600D_600D) begin n_fail++; $display("FAIL rmid_new_inst: got %h want 600d600d", inst); end
        n_checks++; if (inst_pc !== RPC) begin n_fail++; $display("FAIL rmid_new_pc: got %h want %h", inst_pc, RPC); end
    endtask

    task automatic test_random();
        bit mem_pending;
        int mem_delay;
        logic [63:0] head;
        do_reset();
        mem_pending = 1'b0;
        mem_delay   = 0;
        for (int i = 0; i < 3000; i++) begin
            imem_gnt       = ($urandom % 4) != 0;
            inst_ready     = ($urandom % 2) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = $urandom;
            if (mem_pending && mem_delay == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = $urandom;
                mem_pending = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                if (mem_pending) mem_delay--;
            end
            #2;
            n_checks++; if (imem_req !== exp_req()) begin n_fail++; $display("FAIL rand_req @%0d: got %b want %b", i, imem_req, exp_req()); end
            n_checks++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rand_addr @%0d: got %h want %h", i, imem_addr, m_pc); end
            n_checks++; if (inst_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rand_valid @%0d: got %b want %0d", i, inst_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                head = m_q[0];
                n_checks++; if ({inst_pc, inst} !== head) begin n_fail++; $display("FAIL rand_head @%0d: got %h/%h want %h/%h", i, inst_pc, inst, head[63:32], head[31:0]); end
            end
            cycle();
            if (m_granted) begin
                mem_pending = 1'b1;
                mem_delay   = $urandom_range(0, 2);
            end
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C00_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter IBUF_DEPTH, default 2, meaning the instruction buffer entry count (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  fetch request valid.
REQ-006 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  response data valid.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port inst_valid  output  1  buffer head valid toward decoder.
REQ-013 SHALL have port inst  output  32  buffer head instruction (feeds decoder inst input).
REQ-014 SHALL have port inst_pc  output  32  PC of buffer head.
REQ-015 SHALL have port inst_ready  input  1  decoder consumes head this cycle.

Function
REQ-016 SHALL hold fetch_pc, a 3-state FSM (IDLE, WAIT, DROP), a FIFO of {pc, inst} with count 0..IBUF_DEPTH, and req_pc (PC of outstanding request).
REQ-017 SHALL assert imem_req combinationally iff state==IDLE, count<IBUF_DEPTH, redirect_valid==0; imem_addr SHALL equal fetch_pc at all times.
REQ-018 SHALL, on imem_req&imem_gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), IDLE->WAIT.
REQ-019 SHALL allow at most one outstanding request; responses assumed >=1 cycle after grant.
REQ-020 SHALL, in WAIT with imem_rvalid and no redirect: push {req_pc, imem_rdata}, WAIT->IDLE; next issue no earlier than following cycle.
REQ-021 SHALL ignore imem_rvalid in IDLE.
REQ-022 SHALL drive inst_valid=(count!=0); inst/inst_pc SHALL show FIFO head; pop on inst_valid&inst_ready.
REQ-023 SHALL allow push and pop in the same cycle (count unchanged, order preserved, including when count==IBUF_DEPTH... only pop-then-push semantics since push never occurs at full per REQ-017).
REQ-024 SHALL, on redirect_valid: flush FIFO (count<=0, inst_valid=0 next cycle), fetch_pc<={redirect_pc[31:2],2'b00}; redirect has priority over push, pop, grant.
REQ-025 SHALL on redirect: IDLE->IDLE; WAIT with imem_rvalid same cycle -> IDLE, data discarded; WAIT without imem_rvalid -> DROP; DROP stays DROP.
REQ-026 SHALL, in DROP with imem_rvalid and no redirect: discard data, DROP->IDLE, no push.
REQ-027 SHALL ignore imem_gnt when imem_req==0.

Reset
REQ-028 SHALL on rst_n==0 at a clock edge set fetch_pc=RESET_PC, state=IDLE, count=0, FIFO storage/head pointers=0, so inst_valid=0, inst=0, inst_pc=0.
REQ-029 SHALL drive imem_req=0 while rst_n==0; reset mid-request discards any outstanding response (later rvalid in IDLE ignored).
REQ-030 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n rises.

Verification
REQ-031 SHALL cover: reset release, gnt immediate, rvalid 1 cycle later with 32'h0280_0400, inst_ready=1 -> inst_valid=1, inst=32'h0280_0400, inst_pc=32'h1C00_0000; next imem_addr=32'h1C00_0004.
REQ-032 SHALL cover: inst_ready=0 for 10 cycles with immediate gnt/rvalid -> exactly 2 entries (pc 1C000000, 1C000004), imem_req=0 while full; one pop re-enables imem_req with addr 1C000008.
REQ-033 SHALL cover: redirect_valid with redirect_pc=32'h1C00_0103 while in WAIT, rvalid 2 cycles later -> response dropped, FIFO empty, next imem_addr=32'h1C00_0100, next inst_pc=32'h1C00_0100.
REQ-034 SHALL cover: redirect coincident with rvalid in WAIT and with a pop -> no push, count=0, state IDLE next cycle.
REQ-035 SHALL cover: redirect_pc=32'hFFFF_FFFC, two fetches -> inst_pc sequence FFFF_FFFC then 0000_0000.
REQ-036 SHALL cover: rst_n low for one cycle while in WAIT, rvalid arrives after release -> ignored, imem_addr=RESET_PC, inst_valid stays 0 until new response.
